pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the five-stage CPU core. It arbitrates stall requests from the ID, EX and MEM stages into one per-stage stall vector for the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences exception and ERET redirects through a freeze–flush–refill state machine. It also maintains a MEM-stall watchdog and a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions for the pipeline stall/flush controller:
// stall-vector constants, stage bit indices, FSM state encoding and the CP0 exception vector.
package pipe_ctrl_pkg;

    localparam logic [31:0] CP0_EXC_VECTOR = 32'hBFC0_0380;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/redirect bundle between the pipeline stages (master) and the controller (slave).
interface pipe_ctrl_if;

    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_valid;
    logic        excp_eret;
    logic [31:0] cp0_epc;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic        new_pc_valid;
    logic [31:0] new_pc;
    logic        bus_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_eret, cp0_epc, perf_clr,
        input  stall, flush, new_pc_valid, new_pc, bus_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_eret, cp0_epc, perf_clr,
        output stall, flush, new_pc_valid, new_pc, bus_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall arbiter plus freeze/flush/refill redirect sequencer,
// MEM-stall watchdog and stalled-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = CP0_EXC_VECTOR,
    parameter int unsigned REFILL_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_ctrl_if.slave   bus
);

    state_t      state_q, state_d;
    logic [2:0]  rcnt_q, rcnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    logic [5:0]  stall;
    logic        flush;
    logic        new_pc_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            rcnt_q    <= '0;
            new_pc_q  <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            new_pc_q  <= new_pc_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        new_pc_d = new_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.excp_valid) begin
                    new_pc_d = bus.excp_eret ? bus.cp0_epc : EXC_VECTOR;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_REFILL;
                rcnt_d  = 3'(REFILL_CYCLES - 1);
            end
            ST_REFILL: begin
                if (rcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog restarts at 0 on the terminal count so pulses repeat every TIMEOUT+1 stalled cycles.
    always_comb begin
        wd_d      = '0;
        timeout_d = 1'b0;
        if ((state_q == ST_RUN) && bus.stallreq_mem && !bus.excp_valid) begin
            if (wd_q == 16'(TIMEOUT)) begin
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_comb begin
        stall        = STALL_NONE;
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.excp_valid)        stall = STALL_ALL;
                else if (bus.stallreq_mem) stall = STALL_MEM;
                else if (bus.stallreq_ex)  stall = STALL_EX;
                else if (bus.stallreq_id)  stall = STALL_ID;
            end
            ST_FLUSH: begin
                flush        = 1'b1;
                new_pc_valid = 1'b1;
            end
            default: ;
        endcase
    end

    sat_counter #(.W(32)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (bus.perf_clr),
        .en_i    (stall != STALL_NONE),
        .count_o (bus.stall_cycles)
    );

    assign bus.stall        = stall;
    assign bus.flush        = flush;
    assign bus.new_pc_valid = new_pc_valid;
    assign bus.new_pc       = new_pc_q;
    assign bus.bus_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception/ERET redirect, watchdog,
// counter saturation/clear and mid-sequence reset.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .EXC_VECTOR    (32'hBFC0_0380),
        .REFILL_CYCLES (2),
        .TIMEOUT       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge, where inputs are driven
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
        chk({tag, "_flush"}, 32'(bus.flush), 32'h0);
        chk({tag, "_npv"}, 32'(bus.new_pc_valid), 32'h0);
        chk({tag, "_newpc"}, bus.new_pc, 32'h0);
        chk({tag, "_tmo"}, 32'(bus.bus_timeout), 32'h0);
        chk({tag, "_scyc"}, bus.stall_cycles, 32'h0);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excp_valid   = 1'b0;
        bus.excp_eret    = 1'b0;
        bus.cp0_epc      = 32'h0;
        bus.perf_clr     = 1'b0;

        sample();
        chk_all_zero("reset");
        next_cycle();
        reset_n = 1'b1;

        // stall priority
        next_cycle();
        bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1;
        sample(); chk("id_ex", 32'(bus.stall), 32'h0F);
        next_cycle();
        bus.stallreq_mem = 1'b1;
        sample(); chk("id_ex_mem", 32'(bus.stall), 32'h1F);
        next_cycle();
        bus.stallreq_mem = 1'b0; bus.stallreq_ex = 1'b0;
        sample(); chk("id_only", 32'(bus.stall), 32'h07);
        next_cycle();
        bus.stallreq_id = 1'b0;
        sample();
        chk("no_req", 32'(bus.stall), 32'h00);
        chk("scyc_3", bus.stall_cycles, 32'd3);

        // exception together with a MEM stall: freeze wins
        next_cycle();
        bus.excp_valid = 1'b1; bus.excp_eret = 1'b0; bus.stallreq_mem = 1'b1;
        sample();
        chk("freeze", 32'(bus.stall), 32'h3F);
        chk("freeze_flush", 32'(bus.flush), 32'h0);
        next_cycle();
        bus.excp_valid = 1'b0; bus.stallreq_mem = 1'b0; bus.stallreq_id = 1'b1;
        sample();
        chk("exc_flush", 32'(bus.flush), 32'h1);
        chk("exc_npv", 32'(bus.new_pc_valid), 32'h1);
        chk("exc_newpc", bus.new_pc, 32'hBFC0_0380);
        chk("exc_flush_stall", 32'(bus.stall), 32'h00);
        chk("exc_wd_cleared", 32'(bus.bus_timeout), 32'h0);
        next_cycle(); sample();
        chk("refill1_flush", 32'(bus.flush), 32'h0);
        chk("refill1_npv", 32'(bus.new_pc_valid), 32'h0);
        chk("refill1_stall", 32'(bus.stall), 32'h00);
        next_cycle(); sample();
        chk("refill2_stall", 32'(bus.stall), 32'h00);
        next_cycle(); sample();
        chk("run_again_stall", 32'(bus.stall), 32'h07);
        next_cycle();
        bus.stallreq_id = 1'b0;
        sample(); chk("scyc_5", bus.stall_cycles, 32'd5);

        // ERET with an ignored exception pulse during REFILL
        next_cycle();
        bus.excp_valid = 1'b1; bus.excp_eret = 1'b1; bus.cp0_epc = 32'h8000_1234;
        sample(); chk("eret_freeze", 32'(bus.stall), 32'h3F);
        next_cycle();
        bus.excp_valid = 1'b0; bus.excp_eret = 1'b0;
        sample();
        chk("eret_flush", 32'(bus.flush), 32'h1);
        chk("eret_newpc", bus.new_pc, 32'h8000_1234);
        next_cycle();
        bus.excp_valid = 1'b1;
        sample();
        chk("eret_refill_stall", 32'(bus.stall), 32'h00);
        chk("eret_refill_flush", 32'(bus.flush), 32'h0);
        next_cycle();
        bus.excp_valid = 1'b0;
        sample(); chk("eret_refill2_stall", 32'(bus.stall), 32'h00);
        next_cycle(); sample();
        chk("eret_run_flush", 32'(bus.flush), 32'h0);
        chk("eret_run_npv", 32'(bus.new_pc_valid), 32'h0);
        chk("eret_run_newpc", bus.new_pc, 32'h8000_1234);
        next_cycle(); sample();
        chk("eret_no_second_flush", 32'(bus.flush), 32'h0);

        // watchdog: MEM stall held 10 cycles, TIMEOUT=4 -> pulses in cycles 6 and 11
        for (int i = 1; i <= 12; i++) begin
            next_cycle();
            bus.stallreq_mem = (i <= 10);
            sample();
            chk($sformatf("wd_tmo_%0d", i), 32'(bus.bus_timeout), (i == 6 || i == 11) ? 32'h1 : 32'h0);
            chk($sformatf("wd_stall_%0d", i), 32'(bus.stall), (i <= 10) ? 32'h1F : 32'h00);
        end

        // saturation and clear of the stall counter
        next_cycle();
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFD;
        #1;
        release dut.u_stall_cnt.count_q;
        sample(); chk("sat_preload", bus.stall_cycles, 32'hFFFF_FFFD);
        next_cycle();
        bus.stallreq_mem = 1'b1;
        sample(); chk("sat_fd", bus.stall_cycles, 32'hFFFF_FFFD);
        next_cycle(); sample(); chk("sat_fe", bus.stall_cycles, 32'hFFFF_FFFE);
        next_cycle(); sample(); chk("sat_ff", bus.stall_cycles, 32'hFFFF_FFFF);
        next_cycle(); sample(); chk("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
        next_cycle();
        bus.perf_clr = 1'b1;
        sample(); chk("clr_cycle", bus.stall_cycles, 32'hFFFF_FFFF);
        next_cycle();
        bus.perf_clr = 1'b0; bus.stallreq_mem = 1'b0;
        sample(); chk("clr_zero", bus.stall_cycles, 32'h0);

        // reset asserted during FLUSH
        next_cycle();
        bus.excp_valid = 1'b1; bus.excp_eret = 1'b0;
        next_cycle();
        bus.excp_valid = 1'b0;
        #2;
        chk("rst_pre_flush", 32'(bus.flush), 32'h1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        sample();
        chk_all_zero("rst_hold");
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        bus.stallreq_id = 1'b1;
        sample();
        chk("post_rst_stall", 32'(bus.stall), 32'h07);
        chk("post_rst_flush", 32'(bus.flush), 32'h0);
        chk("post_rst_npv", 32'(bus.new_pc_valid), 32'h0);
        next_cycle();
        bus.stallreq_id = 1'b0;
        sample();
        chk("post_rst_flush2", 32'(bus.flush), 32'h0);
        chk("post_rst_npv2", 32'(bus.new_pc_valid), 32'h0);
        chk("post_rst_newpc", bus.new_pc, 32'h0);
        chk("post_rst_stall2", 32'(bus.stall), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
